// File: rtl/vga_pkg.sv
// Shared constants, lock-state encoding and ball-colour helper for the VGA receiver.
package vga_pkg;

    localparam int H_PIXELS_DEF = 800;
    localparam int V_LINES_DEF  = 521;
    localparam int H_PULSE_DEF  = 96;
    localparam int V_PULSE_DEF  = 2;
    localparam int HBP_DEF      = 144;
    localparam int HFP_DEF      = 784;
    localparam int VBP_DEF      = 31;
    localparam int VFP_DEF      = 511;

    localparam int CNT_W = 10;
    localparam int X_W   = 10;
    localparam int Y_W   = 9;
    localparam int R_W   = 5;
    localparam int G_W   = 6;
    localparam int B_W   = 5;

    localparam logic [R_W-1:0] BALL_R = '0;
    localparam logic [G_W-1:0] BALL_G = '1;
    localparam logic [B_W-1:0] BALL_B = '0;

    typedef enum logic [1:0] {
        S_HUNT   = 2'd0,
        S_LINE   = 2'd1,
        S_FRAME  = 2'd2,
        S_LOCKED = 2'd3
    } lock_state_e;

    function automatic logic is_ball(input logic [R_W-1:0] r,
                                     input logic [G_W-1:0] g,
                                     input logic [B_W-1:0] b);
        return (r == BALL_R) && (g == BALL_G) && (b == BALL_B);
    endfunction

endpackage

// File: rtl/vga_rx_if.sv
// Incoming video bus: sync, colour and the pixel-slot strobe.
interface vga_rx_if;
    import vga_pkg::*;

    // pix_en is a one-pclk strobe; sync and colour are only meaningful in the
    // cycle pix_en is high. There is no back-pressure: every strobe is consumed.
    logic           pix_en;
    logic           hsync;
    logic           vsync;
    logic [R_W-1:0] red;
    logic [G_W-1:0] green;
    logic [B_W-1:0] blue;

    modport master (output pix_en, hsync, vsync, red, green, blue);
    modport slave  (input  pix_en, hsync, vsync, red, green, blue);
endinterface

// File: rtl/vga_obj_tracker.sv
// Tracks the minimum x/y of ball-coloured pixels in a frame and publishes it at frame end.
module vga_obj_tracker
    import vga_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           sample,
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    input  logic [R_W-1:0] red,
    input  logic [G_W-1:0] green,
    input  logic [B_W-1:0] blue,
    input  logic           frame_end,
    input  logic           clear,
    output logic           valid,
    output logic [X_W-1:0] min_x,
    output logic [Y_W-1:0] min_y
);

    logic [X_W-1:0] run_x;
    logic [Y_W-1:0] run_y;
    logic           seen;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_x <= '1;
            run_y <= '1;
            seen  <= 1'b0;
            valid <= 1'b0;
            min_x <= '0;
            min_y <= '0;
        end else if (clear) begin
            run_x <= '1;
            run_y <= '1;
            seen  <= 1'b0;
            valid <= 1'b0;
        end else if (frame_end) begin
            // An empty frame drops valid but keeps the last reported corner.
            valid <= seen;
            if (seen) begin
                min_x <= run_x;
                min_y <= run_y;
            end
            run_x <= '1;
            run_y <= '1;
            seen  <= 1'b0;
        end else if (sample && is_ball(red, green, blue)) begin
            seen <= 1'b1;
            if (x < run_x) run_x <= x;
            if (y < run_y) run_y <= y;
        end
    end

endmodule

// File: rtl/vga_rx.sv
// VGA receiver: sync lock FSM, pixel capture in the active window, ball tracking.
module vga_rx
    import vga_pkg::*;
#(
    parameter int H_PIXELS = H_PIXELS_DEF,
    parameter int V_LINES  = V_LINES_DEF,
    parameter int H_PULSE  = H_PULSE_DEF,
    parameter int V_PULSE  = V_PULSE_DEF,
    parameter int HBP      = HBP_DEF,
    parameter int HFP      = HFP_DEF,
    parameter int VBP      = VBP_DEF,
    parameter int VFP      = VFP_DEF
) (
    input  logic           pclk,
    input  logic           reset,
    vga_rx_if.slave        vid,
    output logic           px_valid,
    output logic [X_W-1:0] px_x,
    output logic [Y_W-1:0] px_y,
    output logic [R_W-1:0] px_r,
    output logic [G_W-1:0] px_g,
    output logic [B_W-1:0] px_b,
    output logic           frame_start,
    output logic           locked,
    output logic           err_line,
    output logic           err_frame,
    output logic           ball_valid,
    output logic [X_W-1:0] ball_x,
    output logic [Y_W-1:0] ball_y,
    output lock_state_e    state
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_PIXELS - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_LINES - 1);
    localparam logic [CNT_W-1:0] H_PUL  = CNT_W'(H_PULSE);
    localparam logic [CNT_W-1:0] V_PUL  = CNT_W'(V_PULSE);
    localparam logic [CNT_W-1:0] H_BP   = CNT_W'(HBP);
    localparam logic [CNT_W-1:0] H_FP   = CNT_W'(HFP);
    localparam logic [CNT_W-1:0] V_BP   = CNT_W'(VBP);
    localparam logic [CNT_W-1:0] V_FP   = CNT_W'(VFP);

    logic             hs_prev, vs_prev;
    logic [CNT_W-1:0] hcount, vcount, h_next, v_next;
    logic             hs_fall, hs_rise, vs_fall, vs_rise, h_sat;
    logic             line_err, frame_err, err_line_d, err_frame_d;
    logic             stay_locked, leave_locked, active, capture, frame_end;
    logic [X_W-1:0]   cur_x;
    logic [Y_W-1:0]   cur_y;
    lock_state_e      state_next;

    always_comb begin
        hs_fall = vid.pix_en &&  hs_prev && !vid.hsync;
        hs_rise = vid.pix_en && !hs_prev &&  vid.hsync;
        vs_fall = vid.pix_en &&  vs_prev && !vid.vsync;
        vs_rise = vid.pix_en && !vs_prev &&  vid.vsync;
        h_sat   = vid.pix_en && !hs_fall && (hcount == '1);

        // h_next/v_next are the coordinates of the pixel sampled on this strobe.
        h_next = hcount;
        if (vid.pix_en) begin
            if (hs_fall)              h_next = '0;
            else if (hcount != '1)    h_next = hcount + CNT_W'(1);
        end
        v_next = vcount;
        if (hs_fall) begin
            if (vs_fall)              v_next = '0;
            else if (vcount != '1)    v_next = vcount + CNT_W'(1);
        end

        line_err  = (hs_fall && (hcount != H_LAST)) || (hs_rise && (h_next != H_PUL)) || h_sat;
        frame_err = (vs_fall && (vcount != V_LAST)) || (vs_rise && (v_next != V_PUL));

        state_next  = state;
        err_line_d  = 1'b0;
        err_frame_d = 1'b0;
        case (state)
            S_HUNT: begin
                if (hs_fall) state_next = S_LINE;
            end
            default: begin
                err_line_d  = line_err;
                err_frame_d = frame_err && (state != S_LINE);
                if (err_line_d || err_frame_d)  state_next = S_HUNT;
                else if (vs_fall)               state_next = (state == S_LINE) ? S_FRAME : S_LOCKED;
            end
        endcase

        stay_locked  = (state == S_LOCKED) && (state_next == S_LOCKED);
        leave_locked = (state == S_LOCKED) && (state_next != S_LOCKED);
        active       = vid.pix_en && (h_next >= H_BP) && (h_next < H_FP) &&
                       (v_next >= V_BP) && (v_next < V_FP);
        capture      = stay_locked && active;
        frame_end    = stay_locked && vs_fall;
        cur_x        = X_W'(h_next - H_BP);
        cur_y        = Y_W'(v_next - V_BP);
    end

    assign locked = (state == S_LOCKED);

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state       <= S_HUNT;
            hs_prev     <= 1'b1;
            vs_prev     <= 1'b1;
            hcount      <= '0;
            vcount      <= '0;
            px_valid    <= 1'b0;
            px_x        <= '0;
            px_y        <= '0;
            px_r        <= '0;
            px_g        <= '0;
            px_b        <= '0;
            frame_start <= 1'b0;
            err_line    <= 1'b0;
            err_frame   <= 1'b0;
        end else begin
            state       <= state_next;
            hcount      <= h_next;
            vcount      <= v_next;
            px_valid    <= capture;
            frame_start <= frame_end;
            err_line    <= err_line_d;
            err_frame   <= err_frame_d;
            if (vid.pix_en) begin
                hs_prev <= vid.hsync;
                vs_prev <= vid.vsync;
            end
            if (capture) begin
                px_x <= cur_x;
                px_y <= cur_y;
                px_r <= vid.red;
                px_g <= vid.green;
                px_b <= vid.blue;
            end
        end
    end

    vga_obj_tracker u_tracker (
        .clk       (pclk),
        .rst       (reset),
        .sample    (capture),
        .x         (cur_x),
        .y         (cur_y),
        .red       (vid.red),
        .green     (vid.green),
        .blue      (vid.blue),
        .frame_end (frame_end),
        .clear     (leave_locked),
        .valid     (ball_valid),
        .min_x     (ball_x),
        .min_y     (ball_y)
    );

endmodule

// File: doc/vga_rx.md
VGA_RX -- requirements
Module: vga_rx

Interface
REQ-001 Parameter H_PIXELS, 800, pixel clocks per line.
REQ-002 Parameter V_LINES, 521, lines per frame.
REQ-003 Parameter H_PULSE, 96, hsync low width in pixel clocks.
REQ-004 Parameter V_PULSE, 2, vsync low width in lines.
REQ-005 Parameters HBP 144, HFP 784, VBP 31, VFP 511: active region is HBP<=hcount<HFP, VBP<=vcount<VFP.
REQ-006 pclk  input  1  sole clock, all logic on rising edge.
REQ-007 reset  input  1  asynchronous, active-high.
REQ-008 pix_en  input  1  one-pclk strobe marking each pixel slot; inputs sampled only when high.
REQ-009 hsync, vsync  input  1 each  sync, low during pulse.
REQ-010 red  input  5, green  input  6, blue  input  5  pixel colour.
REQ-011 px_valid  output  1  one-pclk pulse, active pixel captured.
REQ-012 px_x  output  10, px_y  output  9  active coordinates (hcount-HBP, vcount-VBP).
REQ-013 px_r  output  5, px_g  output  6, px_b  output  5  captured colour.
REQ-014 frame_start  output  1, locked  output  1, err_line  output  1, err_frame  output  1.
REQ-015 ball_valid  output  1, ball_x  output  10, ball_y  output  9  per-frame ball bounding-box min corner.

Function
REQ-016 Inputs SHALL be registered on pix_en; hsync fall = prev 1, current 0 at successive strobes; same for vsync.
REQ-017 hcount (10b) SHALL clear to 0 on hsync fall, else increment each strobe, saturating at 1023.
REQ-018 vcount (10b) SHALL clear to 0 on a strobe with hsync fall and vsync fall together, increment on hsync fall alone.
REQ-019 Lock FSM states HUNT, LINE, FRAME, LOCKED; reset state HUNT.
REQ-020 HUNT -> LINE on first hsync fall; LINE -> FRAME on first vsync fall; FRAME -> LOCKED on next vsync fall when frame had exactly V_LINES lines.
REQ-021 Line error: hsync fall with previous hcount != H_PIXELS-1, hsync rise at hcount != H_PULSE, or hcount saturation; in LINE/FRAME/LOCKED SHALL pulse err_line one pclk and go HUNT.
REQ-022 Frame error: vsync fall with line count != V_LINES, or vsync rise at vcount != V_PULSE; in FRAME/LOCKED SHALL pulse err_frame one pclk and go HUNT.
REQ-023 Line and frame error on same strobe: both pulses assert, FSM goes HUNT.
REQ-024 locked SHALL be high exactly while state is LOCKED.
REQ-025 px_valid SHALL pulse the pclk after a strobe sampling an active-region pixel, only in LOCKED; px_x/px_y/px_r/g/b update with it and hold otherwise.
REQ-026 frame_start SHALL pulse one pclk after each vsync fall while LOCKED (not on the lock-acquiring fall).
REQ-027 Ball pixel: red==0, green==63, blue==0; tracker keeps min x and min y of ball pixels in current frame.
REQ-028 At each vsync fall while LOCKED: ball_valid<=1, ball_x/ball_y<=min if any ball pixel seen, else ball_valid<=0 with coordinates held; trackers then clear.
REQ-029 Leaving LOCKED SHALL clear ball_valid and trackers.

Reset
REQ-030 On reset: all outputs 0, state HUNT, counters 0, sync history regs 1, trackers to max (x=1023, y=511).
REQ-031 Reset mid-frame SHALL abort immediately; relock requires full REQ-020 sequence.

Structure
REQ-032 Package vga_pkg SHALL hold timing constants, colour widths, lock-state enum, ball-colour constants.
REQ-033 Ball tracker SHALL be sub-module vga_obj_tracker (inputs: sample, x, y, colour, frame_end, clear; outputs: valid, min x, min y).

Verification
REQ-034 Nominal timing, pix_en every 5th pclk, 3 frames -> locked high after 2nd vsync fall; 640x480 px_valid pulses per locked frame; px_x 0..639, px_y 0..479.
REQ-035 Ball drawn at x 317..321, y 211..215 -> after next vsync fall ball_valid=1, ball_x=317, ball_y=211.
REQ-036 One line of 799 pixel clocks while LOCKED -> err_line pulse, locked 0, no px_valid until relock.
REQ-037 Frame of 520 lines while LOCKED -> err_frame pulse, state HUNT.
REQ-038 Frame with no green pixels -> ball_valid=0, ball_x/ball_y hold prior values.
REQ-039 Reset asserted mid-line in LOCKED -> all outputs 0 asynchronously; relock only after full sequence.
